// File: rtl/matvec_pkg.sv
// matvec_pkg: shared types and width helpers for the matrix-vector sequencer.
package matvec_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    CLEAR  = 3'd2,
    RUN    = 3'd3,
    OUT    = 3'd4
  } state_t;

  // Ceiling log2, never smaller than 1 so a single-entry range still gets a bit.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // One signed fixed-point element: sign + integer + fractional bits.
  function automatic int bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  // One weight column (one element per output row).
  function automatic int memBitwidth(input int qn, input int qm, input int nrow);
    return bitwidth(qn, qm) * nrow;
  endfunction

  // The whole input vector (one element per column).
  function automatic int layerBitwidth(input int qn, input int qm, input int ncol);
    return bitwidth(qn, qm) * ncol;
  endfunction

endpackage

// File: rtl/matvec_watchdog.sv
// matvec_watchdog: counts RUN cycles and raises a sticky error when dot_prod
// never reports dataReady. Only instantiated when MATVEC_TIMEOUT_EN is defined.
module matvec_watchdog
  import matvec_pkg::*;
#(
  parameter int LIMIT = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  input  logic i_seen,
  input  logic i_clear,
  output logic o_expire,
  output logic o_timeoutErr
);

  localparam int CW = clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeoutErr;

  // Expiry fires in the last allowed RUN cycle if the result still has not shown up.
  assign o_expire     = i_run && !i_seen && (r_cnt == LAST);
  assign o_timeoutErr = r_timeoutErr;

  // RUN-cycle counter, restarted whenever the sequencer leaves RUN.
  always_ff @(posedge clock) begin
    if (!reset || !i_run) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by a new accepted start or by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_timeoutErr <= 1'b0;
    end else if (i_clear) begin
      r_timeoutErr <= 1'b0;
    end else if (o_expire) begin
      r_timeoutErr <= 1'b1;
    end
  end

endmodule

// File: rtl/matvec_ctrl.sv
// matvec_ctrl: sequences one matrix-vector product on dot_prod + weightRAM.
// Streams weight columns, holds dot_prod in reset while loading, runs it,
// captures outputVec and returns it over a valid/ready handshake.
// Optional RUN watchdog with sticky timeoutErr: define MATVEC_TIMEOUT_EN.
module matvec_ctrl
  import matvec_pkg::*;
#(
  parameter int NROW = 32,
  parameter int NCOL = 4,
  parameter int QN   = 6,
  parameter int QM   = 11,
`ifdef MATVEC_TIMEOUT_EN
  parameter int TIMEOUT_SLACK = 8,
`endif
  localparam int BITWIDTH        = bitwidth(QN, QM),
  localparam int MEMORY_BITWIDTH = memBitwidth(QN, QM, NROW),
  localparam int LAYER_BITWIDTH  = layerBitwidth(QN, QM, NCOL),
  localparam int ADDR_BITWIDTH   = clog2(NCOL)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       loadWeights,
  input  logic [LAYER_BITWIDTH-1:0]  xVecIn,
  input  logic [MEMORY_BITWIDTH-1:0] wColIn,
  input  logic                       wValid,
  output logic                       wReady,
  output logic [ADDR_BITWIDTH-1:0]   colAddressWrite,
  output logic [MEMORY_BITWIDTH-1:0] weightMemInput,
  output logic                       writeEn,
  output logic                       dpReset,
  output logic [BITWIDTH-1:0]        inputVec,
  input  logic [ADDR_BITWIDTH-1:0]   colAddressRead,
  input  logic                       dataReady,
  input  logic [MEMORY_BITWIDTH-1:0] outputVec,
  output logic [MEMORY_BITWIDTH-1:0] result,
  output logic                       resultValid,
  input  logic                       resultReady,
  output logic                       busy,
  output logic                       timeoutErr
);

  localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

  state_t                       r_state;
  logic [ADDR_BITWIDTH-1:0]     r_colCnt;
  logic [BITWIDTH-1:0]          r_xElem [NCOL];
  logic                         r_runFirst;
  logic                         r_busy;
  logic                         r_dpReset;
  logic                         r_wReady;
  logic                         r_resultValid;
  logic [MEMORY_BITWIDTH-1:0]   r_result;
  logic                         w_startAcc;
  logic                         w_timeout;
  logic                         w_run;
  logic                         w_seen;
  logic [BITWIDTH-1:0]          w_inputVec;

  assign w_startAcc = (r_state == IDLE) && start;
  assign w_run      = (r_state == RUN);
  assign w_seen     = dataReady && !r_runFirst;

  assign busy            = r_busy;
  assign dpReset         = r_dpReset;
  assign wReady          = r_wReady;
  assign writeEn         = r_wReady && wValid;
  assign colAddressWrite = r_wReady ? r_colCnt : '0;
  assign weightMemInput  = wColIn;
  assign result          = r_result;
  assign resultValid     = r_resultValid;
  assign inputVec        = w_inputVec;

`ifdef MATVEC_TIMEOUT_EN
  matvec_watchdog #(
    .LIMIT(NCOL + TIMEOUT_SLACK)
  ) u_watchdog (
    .clock       (clock),
    .reset       (reset),
    .i_run       (w_run),
    .i_seen      (w_seen),
    .i_clear     (w_startAcc),
    .o_expire    (w_timeout),
    .o_timeoutErr(timeoutErr)
  );
`else
  assign w_timeout  = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  // Latch the input vector once per accepted start so the caller may change xVecIn.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < NCOL; c++) begin
        r_xElem[c] <= '0;
      end
    end else if (w_startAcc) begin
      for (int c = 0; c < NCOL; c++) begin
        r_xElem[c] <= xVecIn[c*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Feed dot_prod the element it is asking for, same cycle; zero outside RUN.
  always_comb begin
    w_inputVec = '0;
    if (r_state == RUN) begin
      w_inputVec = r_xElem[colAddressRead];
    end
  end

  // Sequencer: state plus registered busy/dpReset/wReady/resultValid and the result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_colCnt      <= '0;
      r_runFirst    <= 1'b0;
      r_busy        <= 1'b0;
      r_dpReset     <= 1'b1;
      r_wReady      <= 1'b0;
      r_resultValid <= 1'b0;
      r_result      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_colCnt <= '0;
            r_busy   <= 1'b1;
            r_wReady <= loadWeights;
            r_state  <= loadWeights ? LOAD_W : CLEAR;
          end
        end
        LOAD_W: begin
          if (wValid) begin
            r_colCnt <= r_colCnt + 1'b1;
            if (r_colCnt == LAST_COL) begin
              r_wReady <= 1'b0;
              r_state  <= CLEAR;
            end
          end
        end
        CLEAR: begin
          r_dpReset  <= 1'b0;
          r_runFirst <= 1'b1;
          r_state    <= RUN;
        end
        RUN: begin
          r_runFirst <= 1'b0;
          if (w_timeout) begin
            r_dpReset <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else if (w_seen) begin
            r_result      <= outputVec;
            r_resultValid <= 1'b1;
            r_dpReset     <= 1'b1;
            r_state       <= OUT;
          end
        end
        OUT: begin
          if (resultReady) begin
            r_resultValid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_busy        <= 1'b0;
          r_dpReset     <= 1'b1;
          r_wReady      <= 1'b0;
          r_resultValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/matvec_ctrl.md
# matvec_ctrl

Sequencer for one matrix-vector product on the `dot_prod` + `weightRAM` pair. It streams NCOL weight columns into `weightRAM`, holds `dot_prod` in reset while loading, and releases it to run. It feeds the latched input vector element selected by `colAddressRead` and captures `outputVec` on `dataReady`. The result is returned through a valid/ready handshake. It sits between the layer-level scheduler and the dot-product datapath.

## Interface
- NROW, 32, rows (output elements)
- NCOL, 4, columns (input elements); power of two
- QN, 6, integer bits
- QM, 11, fractional bits
- TIMEOUT_SLACK, 8, cycles allowed beyond NCOL for `dataReady` (macro builds only)
- Derived: BITWIDTH=QN+QM+1, MEMORY_BITWIDTH=BITWIDTH*NROW, LAYER_BITWIDTH=BITWIDTH*NCOL, ADDR_BITWIDTH=log2(NCOL)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- start  in  1  request a product; sampled only in IDLE
- loadWeights  in  1  sampled with `start`; 1 means run the weight-load phase first
- xVecIn  in  LAYER_BITWIDTH  input vector; element c at [c*BITWIDTH+:BITWIDTH]; latched on accepted `start`
- wColIn  in  MEMORY_BITWIDTH  one weight column per beat
- wValid  in  1 / wReady  out  1  weight-column handshake
- colAddressWrite  out  ADDR_BITWIDTH  weightRAM write address
- weightMemInput  out  MEMORY_BITWIDTH  weightRAM write data (equals `wColIn`)
- writeEn  out  1  weightRAM write enable
- dpReset  out  1  active-high reset to `dot_prod`
- inputVec  out  BITWIDTH  element to `dot_prod`
- colAddressRead  in  ADDR_BITWIDTH  from `dot_prod`
- dataReady  in  1  from `dot_prod`
- outputVec  in  MEMORY_BITWIDTH  from `dot_prod`
- result  out  MEMORY_BITWIDTH  captured product
- resultValid  out  1 / resultReady  in  1  result handshake
- busy  out  1  state is not IDLE
- timeoutErr  out  1  sticky error flag (macro builds only)

## Operation
- States: IDLE, LOAD_W, CLEAR, RUN, OUT.
- IDLE: `dpReset`=1. On `start`=1, latch `xVecIn`. Go to LOAD_W if `loadWeights`=1, otherwise go to CLEAR. Clear `timeoutErr`.
- LOAD_W: `wReady`=1 and `dpReset`=1. `writeEn`=`wValid`. On each beat (`wValid`&`wReady`), write the column to address k, then k++. After the beat with k=NCOL-1, go to CLEAR. `wValid` gaps stall the phase with no penalty.
- CLEAR: one cycle with `dpReset`=1. This guarantees the accumulators are zero. Then go to RUN.
- RUN: `dpReset`=0. `inputVec` = latched element[`colAddressRead`]. This is a combinational mux, valid in the same cycle. The first RUN cycle ignores `dataReady`. After that, the first cycle with `dataReady`=1 registers `outputVec` into `result` and moves to OUT.
- OUT: `resultValid`=1 and `dpReset`=1. `result` is stable. When `resultReady`=1, go to IDLE.
- `inputVec`=0 in every state except RUN.
- `start` outside IDLE is ignored; no queueing.
- `colAddressWrite`, `writeEn`, and `wReady` are driven only in LOAD_W. Otherwise all three are 0.
- Reset mid-operation: return to IDLE. A partial weight load is not undone. The caller must reload weights with `loadWeights`=1.

## Timing
- Reset values: state=IDLE, `busy`=0, `dpReset`=1, `wReady`=0, `writeEn`=0, `colAddressWrite`=0, `inputVec`=0, `result`=0, `resultValid`=0, `timeoutErr`=0.
- `start` accepted at edge T gives `busy`=1 from T+1.
- Load latency with continuous `wValid` is NCOL cycles, then 1 CLEAR cycle. RUN begins at T+NCOL+2.
- `dataReady` seen at edge R gives `resultValid`=1 from R+1.
- Handshake completes at the edge where `resultValid`&`resultReady`. `busy`=0 in the next cycle, and a new `start` is accepted there.
- `resultReady` may be held high in advance; the handshake then completes one cycle after `resultValid` rises.

## Configuration
- `MATVEC_TIMEOUT_EN` defined: a RUN-cycle counter runs. If `dataReady` is not seen within NCOL+TIMEOUT_SLACK RUN cycles:
  - set `timeoutErr` (sticky until the next accepted `start` or reset);
  - force `dpReset`=1 and return to IDLE without asserting `resultValid`.
- `MATVEC_TIMEOUT_EN` undefined: no counter, `timeoutErr` tied to 0, and RUN waits indefinitely.

## Structure
- Package `matvec_pkg`: state enum, BITWIDTH/width derivation functions, `clog2` helper.
- Sub-module `matvec_watchdog`: counter plus sticky flag; instantiated only under `MATVEC_TIMEOUT_EN`.
- Top level holds the FSM, column counter, vector latch, input mux and result register.

## Test plan
- Reset, then start with loadWeights=1 and continuous wValid (defaults):
  - writes to addresses 0,1,2,3 on 4 consecutive cycles;
  - `dpReset` falls at the start edge+6;
  - result matches golden for W=I-pattern, x=[1.0,2.0,3.0,4.0] (0x00800, 0x01000, …).
- wValid toggled 1/0 during load → exactly 4 writes, addresses in order, no skipped or duplicated columns.
- Second start with loadWeights=0 → goes IDLE→CLEAR→RUN with no writes; result uses the previously loaded weights.
- resultReady held 0 for 10 cycles → `result` stable, `resultValid` held, `start` pulses ignored, `busy`=1.
- reset=0 asserted in RUN → next cycle all outputs at reset values. A subsequent full run produces the correct result.
- `MATVEC_TIMEOUT_EN`, `dataReady` held 0 → `timeoutErr`=1 after 12 RUN cycles, returns to IDLE, no `resultValid`.
